// File: rtl/div_pkg.sv
// div_pkg: shared types and defaults for the sequencer that drives the
// 8-bit sign-magnitude fractional divider.
//   state_e       : sequencer FSM states
//   err_e         : response status codes carried on rsp_err
//   *_DEF         : default watchdog limits
//   cnt_sat_inc() : saturating increment for the 4-bit watchdog counter
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_RUN     = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK  = 2'd0,
        ERR_DZ  = 2'd1,
        ERR_OVF = 2'd2,
        ERR_TO  = 2'd3
    } err_e;

    localparam int WAIT_HI_MAX_DEF = 4;
    localparam int RUN_MAX_DEF     = 15;
    localparam int CNT_W           = 4;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/div_opnd_chk.sv
// div_opnd_chk: combinational operand screen for the fractional divider.
//   x_i   [7:0] : dividend, sign-magnitude fraction (bit 7 = sign)
//   y_i   [7:0] : divisor, sign-magnitude fraction
//   err_o [1:0] : ERR_DZ when |y| is zero (either sign), else ERR_OVF when
//                 |x| >= |y| (quotient would not be a fraction), else ERR_OK
module div_opnd_chk
    import div_pkg::*;
(
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    output err_e       err_o
);

    logic [6:0] mx, my;

    assign mx = x_i[6:0];
    assign my = y_i[6:0];

    always_comb begin
        err_o = ERR_OK;
        if (my == 7'd0)
            err_o = ERR_DZ;      // +0 and -0 both trap, ahead of overflow
        else if (mx >= my)
            err_o = ERR_OVF;
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: request/response sequencer in front of the 8-bit
// sign-magnitude fractional divider. Accepts one operand pair, screens it,
// launches legal pairs, watches div_busy with watchdogs and holds the result
// until the consumer takes it.
//   clk, rst_n            : clock, async active-low reset (shared with divider)
//   req_valid/req_ready   : request handshake, req_x/req_y operands
//   div_x/div_y/div_start : operands and one-cycle launch pulse to the divider
//   div_busy/div_z/div_r  : divider status, quotient and remainder
//   rsp_valid/rsp_ready   : response handshake, rsp_z/rsp_r/rsp_err result
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WAIT_HI_MAX = WAIT_HI_MAX_DEF,
    parameter int RUN_MAX     = RUN_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [7:0] req_x,
    input  logic [7:0] req_y,
    output logic       req_ready,
    output logic [7:0] div_x,
    output logic [7:0] div_y,
    output logic       div_start,
    input  logic       div_busy,
    input  logic [7:0] div_z,
    input  logic [7:0] div_r,
    output logic       rsp_valid,
    output logic [7:0] rsp_z,
    output logic [7:0] rsp_r,
    output logic [1:0] rsp_err,
    input  logic       rsp_ready
);

    // The counter holds the number of cycles already spent in the state, so
    // the timeout fires on the MAX-th cycle without the awaited busy edge.
    localparam logic [CNT_W-1:0] WH_LIM  = 4'(WAIT_HI_MAX - 1);
    localparam logic [CNT_W-1:0] RUN_LIM = 4'(RUN_MAX - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       x_q, y_q;
    logic             start_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_z_q, rsp_r_q;
    err_e             rsp_err_q;
    err_e             chk_err;

    div_opnd_chk u_chk (
        .x_i   (req_x),
        .y_i   (req_y),
        .err_o (chk_err)
    );

    // Gated with rst_n so ready is low for the whole reset, then high the
    // moment reset releases since the FSM already sits in IDLE.
    assign req_ready = rst_n & (state_q == S_IDLE);
    assign div_x     = x_q;
    assign div_y     = y_q;
    assign div_start = start_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= 8'h00;
            y_q         <= 8'h00;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= 8'h00;
            rsp_r_q     <= 8'h00;
            rsp_err_q   <= ERR_OK;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        x_q <= req_x;
                        y_q <= req_y;
                        if (chk_err != ERR_OK) begin
                            rsp_z_q     <= 8'h00;
                            rsp_r_q     <= 8'h00;
                            rsp_err_q   <= chk_err;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= S_START;
                        end
                    end
                end
                // busy is deliberately not sampled here: a stale high from a
                // previous run must not look like a launch acknowledgement.
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (div_busy) begin
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end else if (cnt_q >= WH_LIM) begin
                        rsp_z_q     <= 8'h00;
                        rsp_r_q     <= 8'h00;
                        rsp_err_q   <= ERR_TO;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_sat_inc(cnt_q);
                    end
                end
                S_RUN: begin
                    if (!div_busy) begin
                        rsp_z_q     <= div_z;
                        rsp_r_q     <= div_r;
                        rsp_err_q   <= ERR_OK;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q >= RUN_LIM) begin
                        rsp_z_q     <= 8'h00;
                        rsp_r_q     <= 8'h00;
                        rsp_err_q   <= ERR_TO;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_sat_inc(cnt_q);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

    localparam int WH  = 4;
    localparam int RUN = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [7:0] req_x, req_y;
    logic [7:0] div_x, div_y;
    logic       div_start, div_busy;
    logic [7:0] div_z, div_r;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_z, rsp_r;
    logic [1:0] rsp_err;

    int ntests = 0;
    int nfail  = 0;

    // Attached divider behaviour: 0 = normal, 1 = busy tied low, 2 = busy stuck high
    int dmode = 0;
    int dlen  = 8;
    int dcnt;

    always #5 clk = ~clk;

    div_seq_ctrl #(.WAIT_HI_MAX(WH), .RUN_MAX(RUN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_start (div_start),
        .div_busy  (div_busy),
        .div_z     (div_z),
        .div_r     (div_r),
        .rsp_valid (rsp_valid),
        .rsp_z     (rsp_z),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready)
    );

    // Sign-magnitude fractional divide: |z| = floor(|x|*128/|y|), sign x^y.
    // This divider reports the remainder magnitude with the inverted divisor
    // sign (so 0.25/0.5 gives remainder 8'h80).
    function automatic logic [15:0] sm_div(input logic [7:0] x, input logic [7:0] y);
        int mx, my, q, rm;
        logic [7:0] z, r;
        mx = int'(x[6:0]);
        my = int'(y[6:0]);
        if (my == 0) return 16'h0000;
        q  = (mx * 128) / my;
        rm = (mx * 128) % my;
        z  = {x[7] ^ y[7], 7'(q)};
        r  = {~y[7], 7'(rm)};
        return {z, r};
    endfunction

    // Busy rises the edge after div_start is seen and stays high dlen cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy <= 1'b0; div_z <= 8'h00; div_r <= 8'h00; dcnt <= 0;
        end else if (dmode == 1) begin
            div_busy <= 1'b0; dcnt <= 0;
        end else if (dmode == 2) begin
            div_busy <= 1'b1; dcnt <= 0;
        end else if (div_start) begin
            div_busy <= 1'b1; dcnt <= dlen;
        end else if (div_busy) begin
            if (dcnt <= 1) begin
                div_busy <= 1'b0;
                {div_z, div_r} <= sm_div(div_x, div_y);
            end else begin
                dcnt <= dcnt - 1;
            end
        end
    end

    // Reference: status, result and cycles from accept edge to first rsp_valid.
    function automatic void ref_model(input logic [7:0] x, input logic [7:0] y,
                                      input int mode, input int len,
                                      output logic [1:0] e, output logic [7:0] z,
                                      output logic [7:0] r, output int lat);
        z = 8'h00; r = 8'h00;
        if (y[6:0] == 7'd0) begin e = 2'd1; lat = 1; end
        else if (x[6:0] >= y[6:0]) begin e = 2'd2; lat = 1; end
        else if (mode == 1) begin e = 2'd3; lat = 1 + WH + 1; end
        else if (mode == 2) begin e = 2'd3; lat = 1 + 2 + RUN; end
        else begin e = 2'd0; {z, r} = sm_div(x, y); lat = 1 + len + 2; end
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_txn(input logic [7:0] x, input logic [7:0] y, input int mode,
                          input int len, input int hold, input string tag);
        logic [1:0] e;
        logic [7:0] ez, er;
        int lat, k, nst, stk, w, exp_st;
        bit got, rdy_bad, hold_bad;
        ref_model(x, y, mode, len, e, ez, er, lat);
        exp_st = (lat > 1) ? 1 : 0;
        dmode = mode;
        dlen  = len;
        req_x = x; req_y = y; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin step(); w++; end
        ntests++;
        if (!req_ready) begin
            nfail++;
            $display("FAIL %s accept: req_ready=%0b after %0d cycles, required 1", tag, req_ready, w);
            req_valid = 1'b0;
            return;
        end
        step();
        req_valid = 1'b0;
        req_x = ~x; req_y = ~y;
        nst = 0; stk = -1; got = 0; rdy_bad = 0;
        for (k = 1; k <= 40; k++) begin
            if (div_start) begin nst++; stk = k; end
            if (rsp_valid) begin got = 1; break; end
            if (req_ready) rdy_bad = 1;
            step();
        end
        ntests++;
        if (!got) begin
            nfail++;
            $display("FAIL %s rsp_timeout: no rsp_valid within 40 cycles, required at %0d", tag, lat);
            return;
        end
        ntests++;
        if (k !== lat) begin nfail++; $display("FAIL %s latency: got %0d required %0d", tag, k, lat); end
        ntests++;
        if (nst !== exp_st) begin nfail++; $display("FAIL %s start_count: got %0d required %0d", tag, nst, exp_st); end
        if (exp_st == 1) begin
            ntests++;
            if (stk !== 1) begin nfail++; $display("FAIL %s start_cycle: got %0d required 1", tag, stk); end
        end
        ntests++;
        if (rdy_bad || req_ready !== 1'b0) begin
            nfail++; $display("FAIL %s ready_busy: req_ready high while busy, required 0", tag);
        end
        ntests++;
        if (rsp_err !== e) begin nfail++; $display("FAIL %s rsp_err: got %0d required %0d", tag, rsp_err, e); end
        ntests++;
        if (rsp_z !== ez) begin nfail++; $display("FAIL %s rsp_z: got %02h required %02h", tag, rsp_z, ez); end
        ntests++;
        if (rsp_r !== er) begin nfail++; $display("FAIL %s rsp_r: got %02h required %02h", tag, rsp_r, er); end
        ntests++;
        if (div_x !== x || div_y !== y) begin
            nfail++; $display("FAIL %s div_xy: got %02h/%02h required %02h/%02h", tag, div_x, div_y, x, y);
        end
        // A legal request offered while the response is held must be ignored.
        req_valid = 1'b1; req_x = 8'h11; req_y = 8'h22;
        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_z !== ez || rsp_r !== er || rsp_err !== e ||
                req_ready !== 1'b0 || div_start !== 1'b0 || div_x !== x) hold_bad = 1;
        end
        if (hold > 0) begin
            ntests++;
            if (hold_bad) begin
                nfail++;
                $display("FAIL %s hold: z=%02h r=%02h err=%0d vld=%0b, required %02h %02h %0d 1", tag, rsp_z, rsp_r, rsp_err, rsp_valid, ez, er, e);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        ntests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || div_x !== x) begin
            nfail++;
            $display("FAIL %s handshake: rsp_valid=%0b req_ready=%0b div_x=%02h, required 0 1 %02h", tag, rsp_valid, req_ready, div_x, x);
        end
    endtask

    task automatic test_reset();
        bit bad;
        rst_n = 1'b0; req_valid = 1'b0; req_x = 8'h00; req_y = 8'h00; rsp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        ntests++;
        if (req_ready !== 1'b0 || div_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_z !== 8'h00 ||
            rsp_r !== 8'h00 || rsp_err !== 2'd0 || div_x !== 8'h00 || div_y !== 8'h00) begin
            nfail++;
            $display("FAIL reset_values: rdy=%0b st=%0b vld=%0b z=%02h r=%02h err=%0d x=%02h y=%02h, required all 0",
                     req_ready, div_start, rsp_valid, rsp_z, rsp_r, rsp_err, div_x, div_y);
        end
        rst_n = 1'b1;
        #1;
        ntests++;
        if (req_ready !== 1'b1) begin nfail++; $display("FAIL reset_release: req_ready=%0b required 1", req_ready); end
        // rsp_ready with nothing pending changes nothing.
        rsp_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || div_start !== 1'b0) bad = 1;
        end
        rsp_ready = 1'b0;
        ntests++;
        if (bad) begin nfail++; $display("FAIL idle_rsp_ready: rsp_valid=%0b req_ready=%0b, required 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_legal();
        do_txn(8'h20, 8'h40, 0, 8, 0, "pos_legal");
        do_txn(8'hA0, 8'h40, 0, 8, 0, "neg_dividend");
        do_txn(8'h05, 8'hFF, 0, 1, 0, "short_busy");
    endtask

    task automatic test_screen();
        do_txn(8'h10, 8'h80, 0, 8, 0, "div_neg_zero");
        do_txn(8'h00, 8'h00, 0, 8, 0, "zero_zero");
        do_txn(8'h40, 8'h40, 0, 8, 0, "ovf_equal");
        do_txn(8'hFF, 8'h7E, 0, 8, 0, "ovf_greater");
    endtask

    task automatic test_timeout();
        do_txn(8'h10, 8'h40, 1, 8, 0, "to_busy_low");
        do_txn(8'h10, 8'h40, 2, 8, 0, "to_busy_stuck");
        dmode = 0;
        step(); step();
        do_txn(8'h3F, 8'h40, 0, 6, 0, "after_timeout");
    endtask

    task automatic test_backpressure();
        do_txn(8'h21, 8'h63, 0, 8, 5, "bp_legal");
        do_txn(8'h21, 8'h00, 0, 8, 5, "bp_err");
    endtask

    task automatic test_reset_in_run();
        int w;
        dmode = 0; dlen = 9;
        req_x = 8'h30; req_y = 8'h50; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin step(); w++; end
        step();
        req_valid = 1'b0;
        // now in START: an async reset must kill the launch pulse at once
        rst_n = 1'b0;
        #1;
        ntests++;
        if (div_start !== 1'b0 || req_ready !== 1'b0 || div_x !== 8'h00) begin
            nfail++; $display("FAIL rst_start: div_start=%0b req_ready=%0b div_x=%02h, required 0 0 00", div_start, req_ready, div_x);
        end
        #1 rst_n = 1'b1;
        step();
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin step(); w++; end
        step();
        req_valid = 1'b0;
        step(); step(); step();   // START, WAIT_HI, into RUN
        rst_n = 1'b0;
        #1;
        ntests++;
        if (rsp_valid !== 1'b0 || div_start !== 1'b0 || req_ready !== 1'b0 || rsp_err !== 2'd0 ||
            rsp_z !== 8'h00 || rsp_r !== 8'h00 || div_x !== 8'h00 || div_y !== 8'h00) begin
            nfail++;
            $display("FAIL rst_run: vld=%0b st=%0b rdy=%0b err=%0d x=%02h y=%02h, required all 0", rsp_valid, div_start, req_ready, rsp_err, div_x, div_y);
        end
        #1 rst_n = 1'b1;
        step();
        do_txn(8'h30, 8'h50, 0, 8, 1, "post_reset");
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        int mode, len, hold;
        for (int i = 0; i < 25; i++) begin
            y = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (y[6:0] == 7'd0) y[0] = 1'b1;
                x = {1'($urandom), 7'($urandom_range(0, int'(y[6:0]) - 1))};
            end else begin
                x = 8'($urandom);
            end
            case ($urandom_range(0, 7))
                0:       mode = 1;
                1:       mode = 2;
                default: mode = 0;
            endcase
            len  = $urandom_range(1, 11);
            hold = $urandom_range(0, 3);
            do_txn(x, y, mode, len, hold, "random");
            dmode = 0;
            step(); step();
        end
    endtask

    task automatic test_back_to_back();
        do_txn(8'h12, 8'h34, 0, 4, 0, "b2b_a");
        do_txn(8'h92, 8'hB4, 0, 4, 0, "b2b_b");
        do_txn(8'h7F, 8'h01, 0, 4, 0, "b2b_c");
    endtask

    initial begin
        test_reset();
        test_legal();
        test_screen();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_in_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Request/response sequencer that sits directly upstream of the 8-bit sign-magnitude fractional divider and owns its start/busy protocol. It accepts one operand pair through a valid/ready handshake and screens it for divide-by-zero and quotient overflow. Legal pairs are launched into the divider. The block then tracks the divider's busy signal with watchdog timeouts, captures quotient and remainder, and holds the result until the consumer takes it.

## Interface
- `WAIT_HI_MAX`, default 4: maximum cycles in WAIT_HI for `div_busy` to rise.
- `RUN_MAX`, default 15: maximum cycles in RUN for `div_busy` to fall.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, 1: operand pair present.
- `req_x`, input, 8: dividend, sign-magnitude fraction with bit 7 as sign.
- `req_y`, input, 8: divisor, sign-magnitude fraction.
- `req_ready`, output, 1: block can accept a request.
- `div_x`, output, 8: dividend to the divider.
- `div_y`, output, 8: divisor to the divider.
- `div_start`, output, 1: one-cycle launch pulse.
- `div_busy`, input, 1: divider busy.
- `div_z`, input, 8: divider quotient.
- `div_r`, input, 8: divider remainder.
- `rsp_valid`, output, 1: result present.
- `rsp_z`, output, 8: quotient.
- `rsp_r`, output, 8: remainder.
- `rsp_err`, output, 2: result status. 0 = OK, 1 = divide-by-zero, 2 = overflow, 3 = timeout.
- `rsp_ready`, input, 1: consumer takes the result.

## Operation
- **States:** IDLE, START, WAIT_HI, RUN, RESP.
- **IDLE**
  - `req_ready`=1 only in this state.
  - On `req_valid`&&`req_ready`, register x and y into operand registers. `div_x`/`div_y` are driven from these registers and stay stable until the next accept.
  - The screen is evaluated on `req_x[6:0]` (mx) and `req_y[6:0]` (my):
    - my==0 gives err 1. This covers +0 and −0 and has priority over overflow.
    - Otherwise mx>=my gives err 2.
    - Otherwise the request is legal.
  - Legal request: go to START.
  - Error: go to RESP with `rsp_z`=0, `rsp_r`=0 and `rsp_err` set. The divider is never started.
- **START:** `div_start`=1 for exactly this one cycle, then go to WAIT_HI with the watchdog counter cleared.
- **WAIT_HI**
  - `div_busy`=1: go to RUN and clear the counter.
  - Counter reaches `WAIT_HI_MAX`: timeout path.
- **RUN**
  - First cycle with `div_busy`=0: register `rsp_z`<=`div_z`, `rsp_r`<=`div_r`, `rsp_err`<=0, then go to RESP.
  - Counter reaches `RUN_MAX`: timeout path.
- **Timeout path:** `rsp_err`=3, `rsp_z`=0, `rsp_r`=0, go to RESP.
- **RESP:** `rsp_valid`=1. `rsp_*` are held constant until `rsp_ready`=1, then go to IDLE.
- **Width rules:** no arithmetic on data besides the 7-bit magnitude compare; all data ports are 8 bits. The watchdog counter is 4 bits and saturates.

## Timing
- **Reset values:** `req_ready`=0 while `rst_n`=0 and 1 after release (state IDLE). `div_start`=0, `rsp_valid`=0, `rsp_z`/`rsp_r`/`div_x`/`div_y`=8'h00, `rsp_err`=0.
- **Error latency:** accept at edge T gives `rsp_valid` high from T+1.
- **Legal latency:**
  - `div_start` is high in cycle T+1.
  - `rsp_valid` rises one cycle after the first RUN cycle that sees `div_busy`=0.
  - With the 8-bit divider attached, total latency is at most 14 cycles.
- **Back-to-back:** no accept in the response cycle; `req_ready` returns the cycle after the `rsp_valid`&&`rsp_ready` handshake.
- **Ignored inputs:** `rsp_ready` without `rsp_valid` is ignored. `req_valid` outside IDLE is ignored and is not queued.
- **Reset mid-operation:** returns to IDLE asynchronously and drops `rsp_valid`/`div_start` immediately. The divider shares `rst_n`.
- **Busy already high in START:** `div_busy` asserted at START from a stale run is not treated as completion. The first busy rise is only looked for from WAIT_HI.

## Structure
- **Shared package `div_pkg`:** state enum, `rsp_err` codes (`ERR_OK`, `ERR_DZ`, `ERR_OVF`, `ERR_TO`), and default `WAIT_HI_MAX`/`RUN_MAX`.
- **Sub-module `div_opnd_chk`:** combinational screen, (x,y) in and 2-bit error code out. It is reused later by the restoring-divider wrapper.
- **Bench top:** instantiates the controller with the alternating-sign divider on the `div_*` ports.

## Test plan
- **Positive legal pair:** x=8'h20, y=8'h40, `rsp_ready`=1 → one `div_start` pulse; `rsp_z`=8'h40, `rsp_r`=8'h80, `rsp_err`=0, within 14 cycles.
- **Negative dividend:** x=8'hA0, y=8'h40 → `rsp_z`=8'hC0, `rsp_r`=8'h80, `rsp_err`=0.
- **Screen errors:**
  - y=8'h80 (−0) → `rsp_err`=1 at T+1, no `div_start`.
  - x=8'h40, y=8'h40 → `rsp_err`=2, no `div_start`.
- **Timeout:** `div_busy` tied 0 → `rsp_err`=3 exactly `WAIT_HI_MAX`+1 cycles after `div_start`. `div_busy` stuck 1 → `rsp_err`=3 after `RUN_MAX` RUN cycles.
- **Backpressure:** `rsp_ready` low for 5 cycles → `rsp_z`/`rsp_r`/`rsp_err` stable; a second `req_valid` is not accepted until the cycle after the handshake.
- **Reset in RUN:** pulse `rst_n` low during RUN → all outputs return to reset values asynchronously; a fresh request afterwards completes correctly.
